// File: rtl/ring_period_counter_if.sv
// Software-side control/readout bundle of the ring period counter.
interface ring_period_counter_if #(
   parameter int CNT_W = 32,
   parameter int WIN_W = 32
);
   logic             start;
   logic [WIN_W-1:0] window_cycles;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [CNT_W-1:0] count;

   modport master (
      output start, window_cycles,
      input  busy, done, overflow, count
   );

   modport slave (
      input  start, window_cycles,
      output busy, done, overflow, count
   );
endinterface

// File: rtl/ring_period_counter.sv
// Enables the adder ring, synchronises its output and counts rising edges
// over a programmable window of wb_clk_i cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; ring off
// S_RUN   | ring on, window counting down, edges counted
// S_DRAIN | ring off, SYNC_STAGES cycles flushing edges still in synchroniser
// S_DONE  | result held stable; start accepted as in S_IDLE
module ring_period_counter #(
   parameter int CNT_W       = 32,
   parameter int WIN_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 wb_clk_i,
   input  logic                 rst_n,
   input  logic                 chain_in,
   output logic                 ring_en,
   ring_period_counter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [WIN_W-1:0] DRAIN_LEN = WIN_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise;
   logic [WIN_W-1:0]       win_q, win_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   win_tc;
   logic                   counting;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], chain_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign win_tc   = (win_q == WIN_W'(1));
   assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         win_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      count_d = count_q;
      ovf_d   = ovf_q;

      // Saturate rather than wrap; overflow flags the lost edge.
      if (counting && rise) begin
         if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               count_d = '0;
               ovf_d   = 1'b0;
               if (bus.window_cycles == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  win_d   = bus.window_cycles;
               end
            end
         end
         S_RUN: begin
            win_d = win_q - WIN_W'(1);
            if (win_tc) begin
               state_d = S_DRAIN;
               win_d   = DRAIN_LEN;
            end
         end
         S_DRAIN: begin
            win_d = win_q - WIN_W'(1);
            if (win_tc) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Decoded straight from state so reset drops the ring without waiting a clock.
   assign ring_en      = (state_q == S_RUN);
   assign bus.busy     = counting;
   assign bus.done     = (state_q == S_DONE);
   assign bus.overflow = ovf_q;
   assign bus.count    = count_q;

endmodule
